// File: rtl/matmul_ctrl.sv
// matmul_ctrl
// -----------
// Clocked sequencer for C = A x B on single-precision matrices held in word
// memory. Each matrix is stored as {rows, cols, elements row-major}, with
// element (r,c) at base + 8 + 4*(r*cols + c). The controller reads the four
// header words, checks that the shapes are compatible, writes the C header,
// then runs the i/j/k loop nest. Each multiply-accumulate step goes through
// an external fused multiply-add unit over a req/ack handshake. Each finished
// dot product is written to C.
//
// Ports
//   clk, reset              clock; synchronous active-high reset to IDLE
//   start                   begin a run (sampled only while idle)
//   addr_a/addr_b/addr_c    matrix base byte addresses, captured on start
//   mem_re/mem_we           read / write strobes (never both high)
//   mem_addr/mem_wdata      byte address and write data
//   mem_rdata               read data, valid the cycle after mem_re
//   fma_req                 operands valid; held through the ack cycle
//   fma_a/fma_b/fma_c       operands, result = a*b + c
//   fma_ack/fma_result      one-cycle completion pulse and its result
//   busy                    a run is in progress
//   done                    one-cycle pulse on successful completion
//   err                     sticky dimension error, cleared by the next start

module matmul_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr_a,
  input  logic [31:0] addr_b,
  input  logic [31:0] addr_c,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        fma_req,
  output logic [31:0] fma_a,
  output logic [31:0] fma_b,
  output logic [31:0] fma_c,
  input  logic        fma_ack,
  input  logic [31:0] fma_result,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HA0, S_HA1, S_HB0, S_HB1, S_CHK, S_WH0, S_WH1,
    S_RDA,  S_RDB, S_FMA, S_WRC, S_DONE, S_ERR
  } state_t;

  state_t      state_q;

  // Captured bases and header words.
  logic [31:0] a_base_q, b_base_q, c_base_q;
  logic [31:0] rows_a_q, cols_a_q, rows_b_q, cols_b_q;
  logic [31:0] stride_a_q;   // 4*K: byte distance between rows of A
  logic [31:0] stride_b_q;   // 4*N: byte distance between rows of B

  // Loop counters; dimensions are limited to 16 bits by the header check.
  logic [15:0] i_q, j_q, k_q;
  logic [31:0] acc_q;

  // Address pointers, advanced by addition only.
  logic [31:0] a_row_q;      // address of A(i,0)
  logic [31:0] a_ptr_q;      // address of A(i,k)
  logic [31:0] b_col_q;      // address of B(0,j)
  logic [31:0] b_ptr_q;      // address of B(k,j)
  logic [31:0] c_ptr_q;      // address of C(i,j)

  logic [31:0] b_hold_q;     // B operand, held after its read-data cycle
  logic        fma_first_q;  // first cycle of the FMA state

  // Registered outputs.
  logic        mem_re_q, mem_we_q, fma_req_q, busy_q, done_q, err_q;
  logic [31:0] mem_addr_q, mem_wdata_q, fma_a_q, fma_c_q;

  // Next-row pointers and loop-end flags.
  logic [31:0] a_row_d, b_col_d;
  logic        k_last, j_last, i_last;
  logic        dims_bad;

  assign a_row_d = a_row_q + stride_a_q;
  assign b_col_d = b_col_q + 32'd4;
  assign k_last  = (k_q == cols_a_q[15:0] - 16'd1);
  assign j_last  = (j_q == cols_b_q[15:0] - 16'd1);
  assign i_last  = (i_q == rows_a_q[15:0] - 16'd1);

  // Evaluated in CHK, where B cols is still on the read-data bus.
  assign dims_bad = (cols_a_q != rows_b_q)
                  || (rows_a_q == 32'd0) || (cols_a_q == 32'd0)
                  || (rows_b_q == 32'd0) || (mem_rdata == 32'd0)
                  || (rows_a_q[31:16] != 16'd0) || (cols_a_q[31:16] != 16'd0)
                  || (rows_b_q[31:16] != 16'd0) || (mem_rdata[31:16] != 16'd0);

  always_ff @(posedge clk) begin
    // NOTE: every state register here uses non-blocking assignment, so all
    // right-hand sides see the values from before this clock edge.
    if (reset) begin
      state_q     <= S_IDLE;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
      rows_a_q    <= '0;
      cols_a_q    <= '0;
      rows_b_q    <= '0;
      cols_b_q    <= '0;
      stride_a_q  <= '0;
      stride_b_q  <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      a_row_q     <= '0;
      a_ptr_q     <= '0;
      b_col_q     <= '0;
      b_ptr_q     <= '0;
      c_ptr_q     <= '0;
      b_hold_q    <= '0;
      fma_first_q <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fma_req_q   <= 1'b0;
      fma_a_q     <= '0;
      fma_c_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless the transition below re-asserts them.
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;

      // Each transition sets up the bus outputs of the state it enters.
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_base_q   <= addr_a;
            b_base_q   <= addr_b;
            c_base_q   <= addr_c;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            mem_re_q   <= 1'b1;
            mem_addr_q <= addr_a;
            state_q    <= S_HA0;
          end
        end
        S_HA0: begin
          mem_re_q   <= 1'b1;
          mem_addr_q <= a_base_q + 32'd4;
          state_q    <= S_HA1;
        end
        S_HA1: begin
          rows_a_q   <= mem_rdata;
          mem_re_q   <= 1'b1;
          mem_addr_q <= b_base_q;
          state_q    <= S_HB0;
        end
        S_HB0: begin
          cols_a_q   <= mem_rdata;
          mem_re_q   <= 1'b1;
          mem_addr_q <= b_base_q + 32'd4;
          state_q    <= S_HB1;
        end
        S_HB1: begin
          rows_b_q <= mem_rdata;
          state_q  <= S_CHK;
        end
        S_CHK: begin
          cols_b_q <= mem_rdata;
          if (dims_bad) begin
            state_q <= S_ERR;
          end else begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= c_base_q;
            mem_wdata_q <= rows_a_q;
            state_q     <= S_WH0;
          end
        end
        S_WH0: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= c_base_q + 32'd4;
          mem_wdata_q <= cols_b_q;
          stride_a_q  <= {cols_a_q[29:0], 2'b00};
          stride_b_q  <= {cols_b_q[29:0], 2'b00};
          i_q         <= '0;
          j_q         <= '0;
          k_q         <= '0;
          acc_q       <= '0;
          a_row_q     <= a_base_q + 32'd8;
          a_ptr_q     <= a_base_q + 32'd8;
          b_col_q     <= b_base_q + 32'd8;
          b_ptr_q     <= b_base_q + 32'd8;
          c_ptr_q     <= c_base_q + 32'd8;
          state_q     <= S_WH1;
        end
        S_WH1: begin
          mem_re_q   <= 1'b1;
          mem_addr_q <= a_ptr_q;
          state_q    <= S_RDA;
        end
        S_RDA: begin
          mem_re_q   <= 1'b1;
          mem_addr_q <= b_ptr_q;
          state_q    <= S_RDB;
        end
        S_RDB: begin
          fma_a_q     <= mem_rdata;
          fma_c_q     <= acc_q;
          fma_req_q   <= 1'b1;
          fma_first_q <= 1'b1;
          state_q     <= S_FMA;
        end
        S_FMA: begin
          fma_first_q <= 1'b0;
          if (fma_first_q) begin
            b_hold_q <= mem_rdata;
          end
          if (fma_ack) begin
            acc_q     <= fma_result;
            fma_req_q <= 1'b0;
            if (k_last) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= c_ptr_q;
              mem_wdata_q <= fma_result;
              state_q     <= S_WRC;
            end else begin
              k_q        <= k_q + 16'd1;
              a_ptr_q    <= a_ptr_q + 32'd4;
              b_ptr_q    <= b_ptr_q + stride_b_q;
              mem_re_q   <= 1'b1;
              mem_addr_q <= a_ptr_q + 32'd4;
              state_q    <= S_RDA;
            end
          end
        end
        S_WRC: begin
          c_ptr_q <= c_ptr_q + 32'd4;
          k_q     <= '0;
          acc_q   <= '0;
          if (j_last && i_last) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (j_last) begin
            // Next row of C: step A down one row, restart B at column 0.
            j_q        <= '0;
            i_q        <= i_q + 16'd1;
            a_row_q    <= a_row_d;
            a_ptr_q    <= a_row_d;
            b_col_q    <= b_base_q + 32'd8;
            b_ptr_q    <= b_base_q + 32'd8;
            mem_re_q   <= 1'b1;
            mem_addr_q <= a_row_d;
            state_q    <= S_RDA;
          end else begin
            // Next column of C: same A row, B one column to the right.
            j_q        <= j_q + 16'd1;
            a_ptr_q    <= a_row_q;
            b_col_q    <= b_col_d;
            b_ptr_q    <= b_col_d;
            mem_re_q   <= 1'b1;
            mem_addr_q <= a_row_q;
            state_q    <= S_RDA;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ERR: begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign fma_req   = fma_req_q;
  assign fma_a     = fma_a_q;
  assign fma_c     = fma_c_q;
  // B read data arrives in the first FMA cycle, the same cycle fma_req rises,
  // so it is forwarded straight from the bus then and held afterwards.
  assign fma_b     = fma_first_q ? mem_rdata : b_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencer for single-precision matrix multiply C = A × B held in word memory. It reads the row/column headers of A and B and checks compatibility. It then walks the i/j/k loop nest, feeding operand pairs to a shared floating-point fused multiply-add unit over a request/acknowledge handshake, and writes the C header and elements back. It sits between the vector memory port and the FP FMA datapath and replaces free-running combinational index feedback with a clocked FSM.

## Interface
- No parameters. Data width fixed at 32; addresses are byte addresses, word-aligned.
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; forces IDLE
- start  in  1  pulse or level; sampled only in IDLE
- addr_a, addr_b, addr_c  in  32 each  matrix base addresses; captured on accepted start
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe
- mem_addr  out  32  byte address for read or write
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid exactly 1 cycle after the mem_re cycle
- fma_req  out  1  operands valid; held until the fma_ack cycle inclusive
- fma_a, fma_b, fma_c  out  32 each  operands; result = a*b + c; stable while fma_req=1
- fma_ack  in  1  one-cycle pulse; fma_result valid in that cycle
- fma_result  in  32  FMA result
- busy  out  1  high from accepted start until DONE/ERR exit
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky; set on bad dimensions; cleared on next accepted start or reset

## Operation
- Memory layout: word0 = rows, word1 = cols, elements row-major from base+8. Element (r,c) is at base+8+4*(r*cols+c).
- FSM states: IDLE, HA0, HA1, HB0, HB1, CHK, WH0, WH1, RDA, RDB, FMA, WRC, DONE, ERR.
- IDLE: on start, capture the three bases, clear err, set busy, go to HA0.
- HA0..HB1 pipeline: each state issues one header read: A rows (base), A cols (+4), B rows, B cols. Each captures the previous read's data. CHK captures B cols.
- CHK: go to ERR if any of the following holds, else go to WH0:
  - A_cols ≠ B_rows;
  - any dimension is 0;
  - any dimension has bits [31:16] ≠ 0.
- WH0 / WH1: write A_rows to addr_c, then B_cols to addr_c+4. Set i=j=k=0 and acc=32'h0000_0000 (+0.0).
- RDA: read A(i,k). RDB: capture A, read B(k,j). FMA: capture B, assert fma_req with a=A, b=B, c=acc, and hold it.
- On fma_ack:
  - acc ← fma_result.
  - If k < K-1: k+1, go to RDA.
  - Else go to WRC.
- WRC: write acc to C(i,j). Then k=0, acc=+0.0, and advance:
  - j+1;
  - on j wrap to 0, i+1;
  - after the last element (i=M-1, j=N-1), go to DONE; otherwise go to RDA.
- Address generation uses row-base pointers updated by addition (A row base += 4*K, B pointer += 4*N per k, C pointer += 4). No multipliers. All address arithmetic wraps mod 2^32.
- DONE: pulse done, drop busy, go to IDLE. ERR: set err, drop busy, go to IDLE. No memory writes and no fma_req on the error path.
- mem_re and mem_we are never high in the same cycle. fma_req is never high outside FMA.
- start while busy is ignored; the base inputs are not re-sampled.

## Timing
- Reset values: every output 0, state IDLE, acc 0, i/j/k 0.
- Reset mid-operation: next cycle is IDLE. Any pending fma_ack is ignored, no further writes occur, and err is cleared.
- Start to first data read: 8 cycles (IDLE, 4 header reads, CHK, 2 header writes).
- Per MAC step: 2 cycles + FMA wait, where FMA wait is ≥1 cycle and includes the ack cycle. Per C element add 1 cycle (WRC).
- Total with 1-cycle ack: 8 + M·N·(3K+1) + 1 cycles to the done pulse.
- fma_ack arriving in the same cycle fma_req first rises is legal and is consumed in that cycle.

## Test plan
- 2×2 identity: A=[3F800000, 40000000; 40400000, 40800000], B=I, FMA model acks after 1 cycle. Required: C header 2, 2; C elements = A in order at addr_c+8..+20; done pulse at cycle 8+4·7+1; busy low afterwards.
- Mismatch: A 2×3, B 2×2. Required: err=1, busy low, done never pulses, zero mem_we and fma_req events.
- Zero dimension and oversized dimension (rows=0; cols=32'h0001_0000). Required: err each time; err clears on the next valid start.
- 1×1 with variable FMA latency of 0–5 cycles. Required: fma_a, fma_b, fma_c stable throughout fma_req; fma_c=0; C(0,0)=fma_result.
- start pulsed every cycle during a 2×3×2 run. Required: identical write trace to the single-start run.
- reset asserted during FMA of a 3×3 run. Required: all outputs 0 the next cycle, no later writes. A fresh start then completes correctly.
